pipe_hazard_ctrl: RTL

//  Interlock and sequencing controller for the 5-stage MIPS32 pipeline (IF/ID/EX/MEM/WB).
//  - Decodes the ID-stage instruction and tracks in-flight destination registers in an internal scoreboard.
//  - Stalls IF/ID and injects EX bubbles on RAW hazards. There is no forwarding.
//  - Squashes wrong-path work on a taken branch.
//  - Drains the pipe on HLT.
//  - Replaces the ad-hoc taken_branch/halted logic in the datapath.

---
 rtl/pipe_mips32_pkg.sv | 61 ++++++
 rtl/pipe_decode.sv | 34 +++
 rtl/pipe_hazard_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/pipe_mips32_pkg.sv
// Shared opcode map, decode/FSM enums and scoreboard slot type for the
// MIPS32 pipeline interlock controller.
package pipe_mips32_pkg;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  typedef enum logic [2:0] {
    RR_ALU,
    RM_ALU,
    LOAD,
    STORE,
    BRANCH,
    HALT
  } instr_type_e;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } state_e;

  typedef struct packed {
    logic [4:0] dst;
    logic       v;
    logic       br;
  } sb_slot_t;

  // Anything outside the known opcode map is treated as a halt.
  function automatic instr_type_e op_type(input logic [5:0] op);
    instr_type_e t;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: t = RR_ALU;
      OP_ADDI, OP_SUBI, OP_SLTI:                     t = RM_ALU;
      OP_LW:                                         t = LOAD;
      OP_SW:                                         t = STORE;
      OP_BEQZ, OP_BNEQZ:                             t = BRANCH;
      OP_HLT:                                        t = HALT;
      default:                                       t = HALT;
    endcase
    return t;
  endfunction

  function automatic logic slot_hit(input sb_slot_t s, input logic [4:0] src,
                                    input logic used);
    return used && s.v && (s.dst == src);
  endfunction

endpackage

// File: rtl/pipe_decode.sv
// Combinational ID-stage decode: instruction class, source registers actually
// read, and the architectural destination (never r0).
module pipe_decode
  import pipe_mips32_pkg::*;
(
  input  logic [31:0]  i_ir,
  output instr_type_e  o_type,
  output logic [4:0]   o_src1,
  output logic         o_src1_used,
  output logic [4:0]   o_src2,
  output logic         o_src2_used,
  output logic [4:0]   o_dst,
  output logic         o_dst_v
);

  logic w_unused_ir;
  assign w_unused_ir = ^i_ir[10:0];

  always_comb begin
    o_type      = op_type(i_ir[31:26]);
    o_src1      = i_ir[25:21];
    o_src2      = i_ir[20:16];
    o_src1_used = (o_type != HALT) && (o_src1 != 5'd0);
    o_src2_used = ((o_type == RR_ALU) || (o_type == STORE)) && (o_src2 != 5'd0);
    o_dst       = 5'd0;
    case (o_type)
      RR_ALU:       o_dst = i_ir[15:11];
      RM_ALU, LOAD: o_dst = i_ir[20:16];
      default:      o_dst = 5'd0;
    endcase
    o_dst_v     = (o_dst != 5'd0);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Interlock/sequencing controller: RAW stall via a 3-slot destination
// scoreboard, taken-branch squash, HLT drain and a saturating stall counter.
module pipe_hazard_ctrl
  import pipe_mips32_pkg::*;
#(
  parameter int WB_BYPASS = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk1,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [31:0]      id_ir,
  input  logic             br_resolve,
  input  logic             br_taken,
  output logic             issue,
  output logic             stall_if,
  output logic             stall_id,
  output logic             bubble_ex,
  output logic             flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  instr_type_e      w_type;
  logic [4:0]       w_src1, w_src2, w_dst;
  logic             w_src1_used, w_src2_used, w_dst_v;
  state_e           r_state, w_state_nxt;
  sb_slot_t         r_ex, r_mem, r_wb, w_ex_nxt;
  logic             w_hit, w_hz, w_br_req, w_drain_done;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_unused_wb;

  pipe_decode u_decode (
    .i_ir        (id_ir),
    .o_type      (w_type),
    .o_src1      (w_src1),
    .o_src1_used (w_src1_used),
    .o_src2      (w_src2),
    .o_src2_used (w_src2_used),
    .o_dst       (w_dst),
    .o_dst_v     (w_dst_v)
  );

  assign w_unused_wb = r_wb.br;

  always_comb begin
    w_hit = slot_hit(r_ex,  w_src1, w_src1_used) || slot_hit(r_ex,  w_src2, w_src2_used) ||
            slot_hit(r_mem, w_src1, w_src1_used) || slot_hit(r_mem, w_src2, w_src2_used);
    if (WB_BYPASS == 0)
      w_hit = w_hit || slot_hit(r_wb, w_src1, w_src1_used) ||
              slot_hit(r_wb, w_src2, w_src2_used);
  end

  assign w_hz     = id_valid && (r_state == RUN) && w_hit;
  assign w_br_req = br_resolve && br_taken;
  // The WB entry retires this edge, so draining only waits on EX/MEM and
  // halted rises together with an empty scoreboard.
  assign w_drain_done = !r_ex.v && !r_mem.v && !r_ex.br && !r_mem.br;

  always_comb begin
    issue       = 1'b0;
    stall_if    = 1'b0;
    stall_id    = 1'b0;
    bubble_ex   = 1'b0;
    flush       = 1'b0;
    halted      = 1'b0;
    w_state_nxt = r_state;
    case (r_state)
      RUN: begin
        flush     = w_br_req;
        issue     = id_valid && !w_hz && !w_br_req;
        stall_if  = w_hz && !w_br_req;
        stall_id  = w_hz && !w_br_req;
        bubble_ex = w_hz || w_br_req;
        if (issue && (w_type == HALT))
          w_state_nxt = DRAIN;
      end
      DRAIN: begin
        flush     = w_br_req;
        stall_if  = !w_br_req;
        stall_id  = !w_br_req;
        bubble_ex = 1'b1;
        if (w_br_req)
          w_state_nxt = RUN;
        else if (w_drain_done)
          w_state_nxt = HALTED;
      end
      HALTED: begin
        halted   = 1'b1;
        stall_if = 1'b1;
        stall_id = 1'b1;
      end
      default: w_state_nxt = RUN;
    endcase
  end

  always_comb begin
    w_ex_nxt = '0;
    if (issue) begin
      w_ex_nxt.dst = w_dst;
      w_ex_nxt.v   = w_dst_v;
      w_ex_nxt.br  = (w_type == BRANCH);
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RUN;
      r_ex        <= '0;
      r_mem       <= '0;
      r_wb        <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ex    <= w_ex_nxt;
      r_mem   <= r_ex;
      r_wb    <= r_mem;
      if (stall_if && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
    end
  end

  assign stall_cnt = r_stall_cnt;

endmodule
